// File: rtl/pp_tree_pipe.sv
// Pipelined 4:2-compressor reduction tree: NUM_PP rows become a sum/carry pair, or a
// single sum when FINAL_ADD=1. A valid/ready handshake collapses bubbles between stages.
module pp_tree_pipe #(
  parameter int WIDTH     = 64,
  parameter int NUM_PP    = 16,
  parameter int FINAL_ADD = 0,
  parameter int TAG_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_PP*WIDTH-1:0] pp_in,
  input  logic [TAG_W-1:0]        tag_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_sum,
  output logic [WIDTH-1:0]        out_carry,
  output logic [TAG_W-1:0]        tag_out
);

  localparam int S = $clog2(NUM_PP) - 1;
  localparam int L = S + ((FINAL_ADD != 0) ? 1 : 0);

  if (NUM_PP != 4 && NUM_PP != 8 && NUM_PP != 16 && NUM_PP != 32 && NUM_PP != 64) begin : g_bad_num_pp
    $error("pp_tree_pipe: NUM_PP must be one of 4, 8, 16, 32, 64");
  end

  // Two chained full adders per bit; returns {carry << 1, sum} so the pair packs as rows {2j+1, 2j}.
  function automatic logic [2*WIDTH-1:0] compress42(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b,
                                                     input logic [WIDTH-1:0] c,
                                                     input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] cy;
    logic             cin;
    logic             s1;
    logic             cout;
    s   = '0;
    cy  = '0;
    cin = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      s1    = a[i] ^ b[i] ^ c[i];
      cout  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
      s[i]  = s1 ^ d[i] ^ cin;
      cy[i] = (s1 & d[i]) | (s1 & cin) | (d[i] & cin);
      cin   = cout;
    end
    return {cy << 1, s};
  endfunction

  logic [L-1:0] v;
  logic [L-1:0] ready;

  // ready_k = ~v_k | ready_{k+1} unrolled: a stage moves unless it and everything ahead is full and stalled.
  for (genvar k = 0; k < L; k++) begin : g_ready
    assign ready[k] = out_ready | ~(&v[L-1:k]);
  end

  assign in_ready  = ready[0] | flush;
  assign out_valid = v[L-1];

  for (genvar k = 0; k < S; k++) begin : g_red
    localparam int RI = NUM_PP >> k;
    localparam int RO = RI / 2;

    logic [RI*WIDTH-1:0] rows_src;
    logic [RO*WIDTH-1:0] rows_c;
    logic [RO*WIDTH-1:0] rows_q;
    logic [TAG_W-1:0]    tag_src;
    logic [TAG_W-1:0]    tag_q;
    logic                v_src;
    logic                v_q;

    if (k == 0) begin : g_src
      assign rows_src = pp_in;
      assign tag_src  = tag_in;
      assign v_src    = in_valid;
    end else begin : g_src
      assign rows_src = g_red[k-1].rows_q;
      assign tag_src  = g_red[k-1].tag_q;
      assign v_src    = v[k-1];
    end

    for (genvar j = 0; j < RI / 4; j++) begin : g_cmp
      assign rows_c[2*j*WIDTH +: 2*WIDTH] = compress42(rows_src[(4*j)*WIDTH   +: WIDTH],
                                                       rows_src[(4*j+1)*WIDTH +: WIDTH],
                                                       rows_src[(4*j+2)*WIDTH +: WIDTH],
                                                       rows_src[(4*j+3)*WIDTH +: WIDTH]);
    end

    // Data is captured only when a valid set actually moves in; flush clears valid but keeps data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q    <= 1'b0;
        rows_q <= '0;
        tag_q  <= '0;
      end else if (flush) begin
        v_q <= 1'b0;
      end else if (ready[k]) begin
        v_q <= v_src;
        if (v_src) begin
          rows_q <= rows_c;
          tag_q  <= tag_src;
        end
      end
    end

    assign v[k] = v_q;
  end

  if (FINAL_ADD != 0) begin : g_fin
    logic [WIDTH-1:0] sum_q;
    logic [TAG_W-1:0] tag_q;
    logic             v_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        sum_q <= '0;
        tag_q <= '0;
      end else if (flush) begin
        v_q <= 1'b0;
      end else if (ready[L-1]) begin
        v_q <= v[S-1];
        if (v[S-1]) begin
          sum_q <= g_red[S-1].rows_q[WIDTH-1:0] + g_red[S-1].rows_q[2*WIDTH-1:WIDTH];
          tag_q <= g_red[S-1].tag_q;
        end
      end
    end

    assign v[L-1]    = v_q;
    assign out_sum   = sum_q;
    assign out_carry = '0;
    assign tag_out   = tag_q;
  end else begin : g_nofin
    assign out_sum   = g_red[S-1].rows_q[WIDTH-1:0];
    assign out_carry = g_red[S-1].rows_q[2*WIDTH-1:WIDTH];
    assign tag_out   = g_red[S-1].tag_q;
  end

endmodule
